// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA raster timing generator.
// Default constants describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  // Width of raster counters and pixel coordinates
  localparam int COORD_W = 11;

  // Default horizontal timing in pixel clocks
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;

  // Default vertical timing in lines
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;

  // Control bits carried down the sync/active delay line
  typedef struct packed {
    logic hs;   // horizontal sync asserted
    logic vs;   // vertical sync asserted
    logic act;  // active video
  } vga_ctl_t;

  // Total clocks per line from its four region widths
  function automatic int h_total(input int act, input int fp, input int sy, input int bp);
    return act + fp + sy + bp;
  endfunction

  // Total lines per frame from its four region widths
  function automatic int v_total(input int act, input int fp, input int sy, input int bp);
    return act + fp + sy + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: host-side signal bundle of the VGA timing generator.
// master = the timing generator, slave = the host colour pipeline / display.
interface vga_timing_gen_if #(
  parameter int COLOR_W   = 10,
  parameter int CELL_LOG2 = 4
);
  import vga_pkg::*;

  logic                           iEnable;
  logic [COLOR_W-1:0]             iRed;
  logic [COLOR_W-1:0]             iGreen;
  logic [COLOR_W-1:0]             iBlue;
  logic [COORD_W-1:0]             oCoord_X;
  logic [COORD_W-1:0]             oCoord_Y;
  logic                           oCoord_Valid;
  logic                           oLine_Start;
  logic                           oFrame_Start;
  logic                           oVblank_Start;
  logic [COORD_W-CELL_LOG2-1:0]   oCell_X;
  logic [COORD_W-CELL_LOG2-1:0]   oCell_Y;
  logic [CELL_LOG2-1:0]           oCell_Off_X;
  logic [CELL_LOG2-1:0]           oCell_Off_Y;
  logic [COLOR_W-1:0]             oVGA_R;
  logic [COLOR_W-1:0]             oVGA_G;
  logic [COLOR_W-1:0]             oVGA_B;
  logic                           oVGA_H_SYNC;
  logic                           oVGA_V_SYNC;
  logic                           oVGA_BLANK;
  logic                           oVGA_SYNC;
  logic                           oVGA_CLOCK;

  modport master (
    input  iEnable, iRed, iGreen, iBlue,
    output oCoord_X, oCoord_Y, oCoord_Valid, oLine_Start, oFrame_Start, oVblank_Start,
           oCell_X, oCell_Y, oCell_Off_X, oCell_Off_Y,
           oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK
  );

  modport slave (
    output iEnable, iRed, iGreen, iBlue,
    input  oCoord_X, oCoord_Y, oCoord_Valid, oLine_Start, oFrame_Start, oVblank_Start,
           oCell_X, oCell_Y, oCell_Off_X, oCell_Off_Y,
           oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK
  );

endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: parametrised shift register (DEPTH stages of W bits) with a
// reset value. DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
  parameter int             DEPTH   = 2,
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_shift
      logic [W-1:0] r_sr [DEPTH];

      // shift the control word one stage per clock
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
        end else begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with a sync/blank
// delay line matching a host colour pipeline of PIPE_LAT clocks.
// Optional feature macro VGA_CELL_COORD_EN: registered grid-cell outputs;
// when undefined the cell ports are tied to 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT     = DEF_H_ACT,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACT     = DEF_V_ACT,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = 1'b0,
  parameter int COLOR_W   = 10,
  parameter int PIPE_LAT  = 2,
  parameter int CELL_LOG2 = 4
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  vga_timing_gen_if.master   bus
);

  localparam int H_TOTAL = h_total(H_ACT, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_ACT, V_FRONT, V_SYNC, V_BACK);

  localparam logic [COORD_W-1:0] L_ONE    = COORD_W'(1);
  localparam logic [COORD_W-1:0] L_H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] L_V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] L_H_ACT  = COORD_W'(H_ACT);
  localparam logic [COORD_W-1:0] L_V_ACT  = COORD_W'(V_ACT);
  localparam logic [COORD_W-1:0] L_HS_BEG = COORD_W'(H_ACT + H_FRONT);
  localparam logic [COORD_W-1:0] L_HS_END = COORD_W'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] L_VS_BEG = COORD_W'(V_ACT + V_FRONT);
  localparam logic [COORD_W-1:0] L_VS_END = COORD_W'(V_ACT + V_FRONT + V_SYNC);

  generate
    if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_pipe_lat
      $error("vga_timing_gen: PIPE_LAT must be in 0..7");
    end
  endgenerate

  logic [COORD_W-1:0] r_h, r_v;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_valid, r_line, r_frame, r_vblank, r_hs0, r_vs0;
  logic [COLOR_W-1:0] r_red, r_grn, r_blu;
  logic               r_hsync, r_vsync, r_blank;

  logic     w_en, w_act, w_hs, w_vs, w_h0;
  vga_ctl_t w_dl_in, w_dl_out;

  assign w_en  = bus.iEnable;
  assign w_h0  = (r_h == '0);
  assign w_act = w_en && (r_h < L_H_ACT) && (r_v < L_V_ACT);
  assign w_hs  = w_en && (r_h >= L_HS_BEG) && (r_h < L_HS_END);
  assign w_vs  = w_en && (r_v >= L_VS_BEG) && (r_v < L_VS_END);

  // raster counters: h wraps into v; held at (0,0) while disabled
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!w_en) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == L_H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == L_V_LAST) ? '0 : r_v + L_ONE;
    end else begin
      r_h <= r_h + L_ONE;
    end
  end

  // stage 0: coordinates (held outside active video), strobes and control bits
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_x      <= '0;
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_line   <= 1'b0;
      r_frame  <= 1'b0;
      r_vblank <= 1'b0;
      r_hs0    <= 1'b0;
      r_vs0    <= 1'b0;
    end else begin
      if (w_act) begin
        r_x <= r_h;
        r_y <= r_v;
      end
      r_valid  <= w_act;
      r_line   <= w_en && w_h0 && (r_v < L_V_ACT);
      r_frame  <= w_en && w_h0 && (r_v == '0);
      r_vblank <= w_en && w_h0 && (r_v == L_V_ACT);
      r_hs0    <= w_hs;
      r_vs0    <= w_vs;
    end
  end

`ifdef VGA_CELL_COORD_EN
  logic [COORD_W-CELL_LOG2-1:0] r_cell_x, r_cell_y;
  logic [CELL_LOG2-1:0]         r_off_x, r_off_y;

  // cell index/offset registered alongside the coordinates they derive from
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cell_x <= '0;
      r_cell_y <= '0;
      r_off_x  <= '0;
      r_off_y  <= '0;
    end else if (w_act) begin
      r_cell_x <= r_h[COORD_W-1:CELL_LOG2];
      r_cell_y <= r_v[COORD_W-1:CELL_LOG2];
      r_off_x  <= r_h[CELL_LOG2-1:0];
      r_off_y  <= r_v[CELL_LOG2-1:0];
    end else begin
      r_cell_x <= r_cell_x;
      r_cell_y <= r_cell_y;
      r_off_x  <= r_off_x;
      r_off_y  <= r_off_y;
    end
  end

  assign bus.oCell_X     = r_cell_x;
  assign bus.oCell_Y     = r_cell_y;
  assign bus.oCell_Off_X = r_off_x;
  assign bus.oCell_Off_Y = r_off_y;
`else
  assign bus.oCell_X     = '0;
  assign bus.oCell_Y     = '0;
  assign bus.oCell_Off_X = '0;
  assign bus.oCell_Off_Y = '0;
`endif

  assign w_dl_in = '{hs: r_hs0, vs: r_vs0, act: r_valid};

  vga_delay_line #(
    .DEPTH   (PIPE_LAT),
    .W       (3),
    .RST_VAL (3'b000)
  ) u_dly (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .i_d    (w_dl_in),
    .o_q    (w_dl_out)
  );

  // output register; iEnable low blanks at once so the pipe tail never shows
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_red   <= '0;
      r_grn   <= '0;
      r_blu   <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_blank <= 1'b0;
    end else begin
      r_red   <= (w_dl_out.act && w_en) ? bus.iRed   : '0;
      r_grn   <= (w_dl_out.act && w_en) ? bus.iGreen : '0;
      r_blu   <= (w_dl_out.act && w_en) ? bus.iBlue  : '0;
      r_hsync <= (w_dl_out.hs  && w_en) ? SYNC_POL : ~SYNC_POL;
      r_vsync <= (w_dl_out.vs  && w_en) ? SYNC_POL : ~SYNC_POL;
      r_blank <= w_dl_out.act && w_en;
    end
  end

  assign bus.oCoord_X      = r_x;
  assign bus.oCoord_Y      = r_y;
  assign bus.oCoord_Valid  = r_valid;
  assign bus.oLine_Start   = r_line;
  assign bus.oFrame_Start  = r_frame;
  assign bus.oVblank_Start = r_vblank;
  assign bus.oVGA_R        = r_red;
  assign bus.oVGA_G        = r_grn;
  assign bus.oVGA_B        = r_blu;
  assign bus.oVGA_H_SYNC   = r_hsync;
  assign bus.oVGA_V_SYNC   = r_vsync;
  assign bus.oVGA_BLANK    = r_blank;
  assign bus.oVGA_SYNC     = 1'b0;
  assign bus.oVGA_CLOCK    = iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen using a shrunken raster
// (55 clocks x 19 lines) so full frames fit in a short run. Three instances
// with PIPE_LAT 0, 2 and 7 share clock, reset and enable.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 40, HF = 4, HS = 6, HB = 5, HT = 55;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = 19;
  localparam int CW = 10, CL = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   cyc;
  int   errors = 0;
  int   checks = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_W(CW), .CELL_LOG2(CL)) if0 ();
  vga_timing_gen_if #(.COLOR_W(CW), .CELL_LOG2(CL)) if2 ();
  vga_timing_gen_if #(.COLOR_W(CW), .CELL_LOG2(CL)) if7 ();

  vga_timing_gen #(.H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .SYNC_POL(1'b0), .COLOR_W(CW), .PIPE_LAT(0), .CELL_LOG2(CL))
    d0 (.iCLK(clk), .iRST_N(rst_n), .bus(if0));
  vga_timing_gen #(.H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .SYNC_POL(1'b0), .COLOR_W(CW), .PIPE_LAT(2), .CELL_LOG2(CL))
    d2 (.iCLK(clk), .iRST_N(rst_n), .bus(if2));
  vga_timing_gen #(.H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .SYNC_POL(1'b0), .COLOR_W(CW), .PIPE_LAT(7), .CELL_LOG2(CL))
    d7 (.iCLK(clk), .iRST_N(rst_n), .bus(if7));

  // host pipeline: iRed is the coordinate X delayed by each instance's latency
  logic [CW-1:0] h2 [2];
  logic [CW-1:0] h7 [7];
  always @(posedge clk) begin
    h2[0] <= if2.oCoord_X[CW-1:0];
    h2[1] <= h2[0];
    h7[0] <= if7.oCoord_X[CW-1:0];
    for (int j = 1; j < 7; j++) h7[j] <= h7[j-1];
  end

  assign if0.iEnable = en;
  assign if2.iEnable = en;
  assign if7.iEnable = en;
  assign if0.iRed    = if0.oCoord_X[CW-1:0];
  assign if2.iRed    = h2[1];
  assign if7.iRed    = h7[6];
  assign if0.iGreen  = 10'h155;
  assign if2.iGreen  = 10'h155;
  assign if7.iGreen  = 10'h155;
  assign if0.iBlue   = 10'h2aa;
  assign if2.iBlue   = 10'h2aa;
  assign if7.iBlue   = 10'h2aa;

  // clock edges since reset release; after edge k this reads k+1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // expected blank/red for an instance: output shows pixel k-1-lat after edge k
  task automatic chk_align(input string nm, input int lat, input logic blk, input logic [CW-1:0] red);
    int  p;
    bit  a;
    int  er;
    p  = cyc - 2 - lat;
    a  = (p >= 0) && ((p % HT) < HA) && (((p / HT) % VT) < VA);
    er = a ? (p % HT) : 0;
    chk({nm, "_blank"}, {31'd0, blk}, {31'd0, a});
    chk({nm, "_red"}, {22'd0, red}, er);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk_align("lat0", 0, if0.oVGA_BLANK, if0.oVGA_R);
      chk_align("lat2", 2, if2.oVGA_BLANK, if2.oVGA_R);
      chk_align("lat7", 7, if7.oVGA_BLANK, if7.oVGA_R);
    end
  end

  task automatic chk_cell(input string nm, input int x, input int y);
`ifdef VGA_CELL_COORD_EN
    chk({nm, "_cellx"}, 32'(if2.oCell_X), x >> CL);
    chk({nm, "_offx"},  32'(if2.oCell_Off_X), x % 16);
    chk({nm, "_celly"}, 32'(if2.oCell_Y), y >> CL);
    chk({nm, "_offy"},  32'(if2.oCell_Off_Y), y % 16);
`else
    chk({nm, "_cellx"}, 32'(if2.oCell_X), 32'd0 * 32'(x));
    chk({nm, "_offx"},  32'(if2.oCell_Off_X), 32'd0);
    chk({nm, "_celly"}, 32'(if2.oCell_Y), 32'd0 * 32'(y));
    chk({nm, "_offy"},  32'(if2.oCell_Off_Y), 32'd0);
`endif
  endtask

  typedef struct {
    int k; int x; int y;
    bit vld; bit ls; bit fs; bit vb; bit hs; bit vs; bit blk;
  } vec_t;

  vec_t tbl [15];
  int   n_hs, n_blk, n_fs, n_vb, n_ls, n_vs;

  initial begin
    // k: edge index after release; stage 0 shows pixel k, outputs pixel k-3
    tbl[0]  = '{0,    0,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{3,    3,  0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{39,   39, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{40,   39, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{43,   39, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{46,   39, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{47,   39, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{52,   39, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{53,   39, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{55,   0,  1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{58,   3,  1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{660,  39, 11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{773,  39, 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{883,  39, 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1045, 0,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_x",     32'(if2.oCoord_X), 32'd0);
    chk("rst_y",     32'(if2.oCoord_Y), 32'd0);
    chk("rst_valid", 32'(if2.oCoord_Valid), 32'd0);
    chk("rst_strb",  32'({if2.oLine_Start, if2.oFrame_Start, if2.oVblank_Start}), 32'd0);
    chk("rst_hs",    32'(if2.oVGA_H_SYNC), 32'd1);
    chk("rst_vs",    32'(if7.oVGA_V_SYNC), 32'd1);
    chk("rst_blank", 32'(if0.oVGA_BLANK), 32'd0);
    chk("rst_rgb",   32'({if2.oVGA_R, if2.oVGA_G, if2.oVGA_B}), 32'd0);
    chk("vga_sync",  32'(if2.oVGA_SYNC), 32'd0);
    chk("vga_clock", 32'(if2.oVGA_CLOCK), 32'd0);
    chk_cell("rst", 0, 0);

    rst_n  = 1'b1;
    chk_on = 1'b1;

    // table-driven vectors against the PIPE_LAT=2 instance
    for (int i = 0; i < 15; i++) begin
      while (cyc != tbl[i].k + 1) @(negedge clk);
      chk($sformatf("v%0d_x", i),     32'(if2.oCoord_X), tbl[i].x);
      chk($sformatf("v%0d_y", i),     32'(if2.oCoord_Y), tbl[i].y);
      chk($sformatf("v%0d_valid", i), 32'(if2.oCoord_Valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d_line", i),  32'(if2.oLine_Start), 32'(tbl[i].ls));
      chk($sformatf("v%0d_frame", i), 32'(if2.oFrame_Start), 32'(tbl[i].fs));
      chk($sformatf("v%0d_vblk", i),  32'(if2.oVblank_Start), 32'(tbl[i].vb));
      chk($sformatf("v%0d_hs", i),    32'(if2.oVGA_H_SYNC), 32'(tbl[i].hs));
      chk($sformatf("v%0d_vs", i),    32'(if2.oVGA_V_SYNC), 32'(tbl[i].vs));
      chk($sformatf("v%0d_blank", i), 32'(if2.oVGA_BLANK), 32'(tbl[i].blk));
      chk($sformatf("v%0d_grn", i),   32'(if2.oVGA_G), tbl[i].blk ? 32'h155 : 32'd0);
      chk($sformatf("v%0d_blu", i),   32'(if2.oVGA_B), tbl[i].blk ? 32'h2aa : 32'd0);
      chk_cell($sformatf("v%0d", i), tbl[i].x, tbl[i].y);
    end

    // one line: 6 sync clocks and 40 active clocks
    while (cyc != 1101) @(negedge clk);
    n_hs = 0; n_blk = 0;
    for (int i = 0; i < HT; i++) begin
      if (if2.oVGA_H_SYNC == 1'b0) n_hs++;
      if (if2.oVGA_BLANK == 1'b1) n_blk++;
      @(negedge clk);
    end
    chk("line_hs_low", n_hs, HS);
    chk("line_active", n_blk, HA);

    // one frame: single frame/vblank strobe, 12 line strobes, 2 sync lines
    n_fs = 0; n_vb = 0; n_ls = 0; n_vs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (if2.oFrame_Start)  n_fs++;
      if (if2.oVblank_Start) n_vb++;
      if (if2.oLine_Start)   n_ls++;
      if (if2.oVGA_V_SYNC == 1'b0) n_vs++;
      @(negedge clk);
    end
    chk("frame_fs",  n_fs, 1);
    chk("frame_vb",  n_vb, 1);
    chk("frame_ls",  n_ls, VA);
    chk("frame_vs",  n_vs, VS * HT);

    // enable drop at pixel (20,5): blank/syncs idle within PIPE_LAT+1 clocks
    while (cyc != 2 * HT * VT + 5 * HT + 20 + 1) @(negedge clk);
    chk("pre_dis_x", 32'(if2.oCoord_X), 32'd20);
    chk_on = 1'b0;
    en     = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) chk("dis0_idle", 32'({if0.oVGA_BLANK, if0.oVGA_H_SYNC, if0.oVGA_V_SYNC}), 32'd3);
      if (n == 3) chk("dis2_idle", 32'({if2.oVGA_BLANK, if2.oVGA_H_SYNC, if2.oVGA_V_SYNC}), 32'd3);
      if (n == 8) chk("dis7_idle", 32'({if7.oVGA_BLANK, if7.oVGA_H_SYNC, if7.oVGA_V_SYNC}), 32'd3);
    end
    chk("dis_valid", 32'(if2.oCoord_Valid), 32'd0);
    chk("dis_strb",  32'({if2.oLine_Start, if2.oFrame_Start, if2.oVblank_Start}), 32'd0);
    chk("dis_hold",  32'({if2.oCoord_X, if2.oCoord_Y}), 32'({11'd20, 11'd5}));
    chk("dis_red",   32'(if7.oVGA_R), 32'd0);
    chk_cell("dis", 20, 5);

    // enable back: frame strobe on the first clock, then raster advances
    en = 1'b1;
    @(negedge clk);
    chk("en_fs",    32'({if0.oFrame_Start, if2.oFrame_Start, if7.oFrame_Start}), 32'd7);
    chk("en_ls",    32'(if2.oLine_Start), 32'd1);
    chk("en_xy",    32'({if2.oCoord_X, if2.oCoord_Y}), 32'd0);
    @(negedge clk);
    chk("en_x1",    32'(if2.oCoord_X), 32'd1);
    chk("en_fs_off", 32'(if2.oFrame_Start), 32'd0);

    // reset mid-frame at line 6, restart at (0,0)
    repeat (6 * HT + 9) @(negedge clk);
    chk("mid_xy", 32'({if2.oCoord_X, if2.oCoord_Y}), 32'({11'd10, 11'd6}));
    rst_n = 1'b0;
    #1;
    chk("arst_xy",    32'({if2.oCoord_X, if2.oCoord_Y}), 32'd0);
    chk("arst_out",   32'({if2.oCoord_Valid, if2.oVGA_BLANK, if2.oVGA_H_SYNC, if2.oVGA_V_SYNC}), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_fs",     32'({if2.oFrame_Start, if2.oLine_Start, if2.oCoord_Valid}), 32'd7);
    chk("rel_xy",     32'({if2.oCoord_X, if2.oCoord_Y}), 32'd0);
    repeat (2) @(negedge clk);
    chk("rel_blank2", 32'(if2.oVGA_BLANK), 32'd0);
    @(negedge clk);
    chk("rel_blank3", 32'(if2.oVGA_BLANK), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
